// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes the signs afterwards; a zero divisor reports an error.
module div_unit #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIVIDE, S_FIX, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             quo_neg_q, quo_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             op_signed;
  logic             dvs_neg;
  logic [WIDTH:0]   trial;
  logic             ge;

  assign op_signed = SIGNED_EN && signed_op;
  assign dvs_neg   = op_signed && divisor[WIDTH-1];
  assign trial     = {prem_q, dvd_q[WIDTH-1]};
  assign ge        = (trial >= {1'b0, dvs_q});

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    dvd_neg_d = dvd_neg_q;
    quo_neg_d = quo_neg_q;
    quot_d    = quot_q;
    rem_d     = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_neg_d = op_signed && dividend[WIDTH-1];
          quo_neg_d = (op_signed && dividend[WIDTH-1]) ^ dvs_neg;
          dvd_d     = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d     = dvs_neg ? -divisor : divisor;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dvs_q == '0) begin
          // Dividend register is still unshifted, so re-applying its sign restores the original.
          quot_d  = '1;
          rem_d   = dvd_neg_q ? -dvd_q : dvd_q;
          state_d = S_ERROR;
        end else begin
          count_d = CW'(WIDTH);
          prem_d  = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        prem_d  = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], ge};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = quo_neg_q ? -dvd_q : dvd_q;
        rem_d   = dvd_neg_q ? -prem_q : prem_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: working registers are not reset; each is loaded in IDLE/CHECK before it is ever read.
  always_ff @(posedge clk) begin
    count_q   <= count_d;
    dvd_q     <= dvd_d;
    dvs_q     <= dvs_d;
    prem_q    <= prem_d;
    dvd_neg_q <= dvd_neg_d;
    quo_neg_q <= quo_neg_d;
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) || (state_q == S_ERROR);
    error     = (state_q == S_ERROR);
    quotient  = quot_q;
    remainder = rem_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops
// and compares them (including completion latency) whenever done is presented.
module tb_div_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start_s, start_u, signed_op;
  logic [W-1:0] dividend, divisor;
  logic         busy_s, done_s, error_s, busy_u, done_u, error_u;
  logic [W-1:0] quot_s, rem_s, quot_u, rem_u;

  div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy_s), .done(done_s),
    .error(error_s), .quotient(quot_s), .remainder(rem_s));

  div_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy_u), .done(done_u),
    .error(error_u), .quotient(quot_u), .remainder(rem_u));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input bit u);
    exp_t         e;
    logic         d, er;
    logic [W-1:0] qq, rr;
    string        tag;
    tag = u ? "u" : "s";
    d   = u ? done_u : done_s;
    er  = u ? error_u : error_s;
    qq  = u ? quot_u : quot_s;
    rr  = u ? rem_u : rem_s;
    if (er && !d) check({tag, "_error_without_done"}, 32'(er), 32'(d));
    if (d) begin
      if ((u ? q_u.size() : q_s.size()) == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_unexpected_done: got done=1 expected no completion (t=%0t)", tag, $time);
      end else begin
        e = u ? q_u.pop_front() : q_s.pop_front();
        check({tag, "_quotient"},  32'(qq), 32'(e.q));
        check({tag, "_remainder"}, 32'(rr), 32'(e.r));
        check({tag, "_error"},     32'(er), 32'(e.err));
        check({tag, "_latency"},   32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  // Drives one accepted request and records what the monitor must later see.
  task automatic issue(input bit u, input bit sop, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit eerr);
    exp_t e;
    @(negedge clk);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    if (u) start_u = 1'b1; else start_s = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.err = eerr;
    e.cyc = cyc + 1 + (eerr ? 1 : W + 2);
    if (u) q_u.push_back(e); else q_s.push_back(e);
    @(negedge clk);
    start_s  = 1'b0;
    start_u  = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  task automatic wait_idle(input bit u);
    for (int i = 0; i < 100; i++) begin
      if (!(u ? busy_u : busy_s)) return;
      @(negedge clk);
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_idle: got busy=1 after 100 cycles expected 0");
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start_s = 1'b0; start_u = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_s),  32'h0);
    check("rst_done",  32'(done_s),  32'h0);
    check("rst_error", 32'(error_s), 32'h0);
    check("rst_quot",  32'(quot_s),  32'h0);
    check("rst_rem",   32'(rem_s),   32'h0);
    reset = 1'b1;

    // Basic unsigned and signed vectors on the signed-capable instance.
    issue(0, 0, 16'd100,  16'd7,    16'd14,   16'd2,    0); wait_idle(0);
    issue(0, 1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 0); wait_idle(0);
    issue(0, 1, 16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 0); wait_idle(0);
    issue(0, 1, 16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 0); wait_idle(0);
    issue(0, 0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 0); wait_idle(0);
    issue(0, 0, 16'd5,    16'd9,    16'd0,    16'd5,    0); wait_idle(0);
    issue(0, 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0); wait_idle(0);

    // Divide by zero: ERROR one edge after start, IDLE the edge after.
    issue(0, 0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1);
    @(negedge clk);
    check("dz_busy_n1", 32'(busy_s), 32'h1);
    @(negedge clk);
    check("dz_busy_n2", 32'(busy_s), 32'h0);
    issue(0, 1, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1); wait_idle(0);

    // Unsigned-only instance ignores signed_op.
    issue(1, 1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0); wait_idle(1);
    issue(1, 1, 16'hFF9C, 16'd7,    16'h2484, 16'h0000, 0); wait_idle(1);

    // Second start and operand changes while busy are ignored.
    issue(0, 0, 16'd1000, 16'd10, 16'd100, 16'd0, 0);
    @(negedge clk);
    start_s = 1'b1; dividend = 16'd7; divisor = 16'd7;
    @(negedge clk);
    start_s = 1'b0; dividend = 16'd3; divisor = 16'd0;
    wait_idle(0);

    // start held through DONE: no new operation until the IDLE cycle samples it.
    begin
      exp_t e;
      @(negedge clk);
      signed_op = 1'b0; dividend = 16'd50; divisor = 16'd5; start_s = 1'b1;
      e.q = 16'd10; e.r = 16'd0; e.err = 1'b0; e.cyc = cyc + 1 + W + 2;
      q_s.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = done_s;
      end
      check("hold_done_seen", 32'(seen), 32'h1);
      @(negedge clk);
      check("hold_idle_busy", 32'(busy_s), 32'h0);
      start_s = 1'b0;
      @(negedge clk);
      check("hold_no_restart", 32'(busy_s), 32'h0);
    end

    // Reset mid-DIVIDE aborts with no done pulse.
    @(negedge clk);
    signed_op = 1'b0; dividend = 16'h1234; divisor = 16'd3; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(busy_s), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(busy_s),  32'h0);
    check("abort_done",  32'(done_s),  32'h0);
    check("abort_error", 32'(error_s), 32'h0);
    check("abort_quot",  32'(quot_s),  32'h0);
    check("abort_rem",   32'(rem_s),   32'h0);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_still_idle", 32'(busy_s), 32'h0);
    issue(0, 0, 16'h1234, 16'd3, 16'h0611, 16'h0001, 0); wait_idle(0);

    for (int i = 0; i < 50 && (q_s.size() + q_u.size()) != 0; i++) @(negedge clk);
    check("pending_completions", 32'(q_s.size() + q_u.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider with its control FSM and datapath in one block. It divides a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, producing one quotient bit per cycle. It supports signed and unsigned operation and reports divide-by-zero. It sits behind the arithmetic issue logic, which drives it with a start/busy/done handshake.

## Interface
- WIDTH, 16, operand, quotient and remainder width; must be 2 or more.
- SIGNED_EN, 1, 1 enables two's-complement mode via signed_op; 0 forces unsigned and ignores signed_op.
- clk  input  1  the block's single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- start  input  1  request; accepted only in IDLE.
- signed_op  input  1  1 selects signed division; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse; high in DONE and ERROR.
- error  output  1  one-cycle pulse, high only in ERROR; always coincides with done.
- quotient  output  WIDTH  registered result; holds until the next completion or reset.
- remainder  output  WIDTH  registered result; holds until the next completion or reset.

## Operation
- States: IDLE, CHECK, DIVIDE, FIX, DONE, ERROR.
- **IDLE**
  - On start=1, latch operands, signs and mode, then go to CHECK.
  - In signed mode, operands are converted to magnitudes.
  - Operand inputs are don't-care after acceptance.
- **CHECK**
  - Divisor zero: go to ERROR.
  - Otherwise go to DIVIDE, with the iteration counter loaded to WIDTH and the partial remainder cleared.
- **DIVIDE**, once per cycle:
  - Form the trial value from the partial remainder shifted left, with the dividend MSB shifted in.
  - If trial ≥ divisor: partial remainder = trial − divisor and the quotient bit is 1.
  - Otherwise: partial remainder = trial and the quotient bit is 0.
  - Decrement the counter; move to FIX after the WIDTH-th iteration.
  - The trial value is WIDTH+1 bits wide, so there is no overflow at the MSB.
- **FIX**
  - In signed mode, negate the quotient when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Write quotient and remainder to the output registers, then go to DONE.
- **DONE**: done=1, then go to IDLE.
- **ERROR**
  - done=1, error=1; quotient = all ones, remainder = original dividend.
  - Then go to IDLE.
- Signed most-negative ÷ −1 wraps: quotient = most-negative value, remainder = 0, error=0.
- start outside IDLE, including during DONE or ERROR, is ignored. It is not queued.

## Timing
- Reset value of every output is 0: busy, done, error, quotient, remainder. The state returns to IDLE.
- Reset takes priority over all other events, including mid-operation. No done pulse is produced for an aborted operation.
- Normal path, with start sampled at edge N:
  - CHECK at N, DIVIDE from N+1.
  - The iterations occupy edges N+2 through N+WIDTH+1.
  - FIX at edge N+WIDTH+1.
  - DONE and the new quotient/remainder are visible from edge N+WIDTH+2 for one cycle.
  - IDLE at N+WIDTH+3.
- Error path: ERROR, with done=error=1, is visible from edge N+1 for one cycle; IDLE at N+2.
- busy rises at edge N and falls at the edge where the state enters IDLE.
- Minimum start-to-start spacing is WIDTH+4 cycles on the normal path and 3 cycles on the error path.
- The outputs update only on entry to DONE or ERROR; they are stable at all other times.

## Test plan
- Unsigned, WIDTH=16: 100 ÷ 7 -> quotient=14, remainder=2; done is a single pulse 18 edges after the start edge; error=0.
- Signed: −100 ÷ 7 -> quotient=0xFFF2, remainder=0xFFFE. Also 100 ÷ −7 -> quotient=0xFFF2, remainder=0x0002.
- Divide by zero: 0x1234 ÷ 0 -> done=error=1 one cycle after start; quotient=0xFFFF, remainder=0x1234; busy low 2 edges after start.
- Signed 0x8000 ÷ 0xFFFF -> quotient=0x8000, remainder=0, error=0. With SIGNED_EN=0, the same operands give quotient=0, remainder=0x8000.
- Protocol: a second start and operand changes during busy are ignored and results match the first request; holding start high through DONE starts no operation until IDLE.
- Reset: reset=0 mid-DIVIDE -> next edge all outputs 0 and the state is IDLE, with no done pulse; a new start then gives a correct result.
